// File: rtl/bit_serializer_pkg.sv
// Shared constants and state encodings for the bit serializer and the
// downstream sequence detector.
package bit_serializer_pkg;

  localparam logic IDLE_LEVEL_DEF = 1'b0;
  localparam int   CNT_W          = 16;

  // One-hot to match the detector's encoding style.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_SHIFT = 2'b10
  } ser_state_e;

endpackage

// File: rtl/bit_serializer_if.sv
// Producer-side word handshake plus serial output bundle of the bit serializer.
// Handshake: a word transfers on any posedge where in_valid && in_ready; the
// producer keeps in_data stable while in_valid is high and not yet accepted.
interface bit_serializer_if #(
  parameter int WIDTH = 8
) ();
  import bit_serializer_pkg::*;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             bit_en;
  logic             dout;
  logic             dout_valid;
  logic             dout_last;
  logic             busy;
  logic [CNT_W-1:0] words_sent;
  ser_state_e       state;

  modport master (
    output in_data, in_valid, bit_en,
    input  in_ready, dout, dout_valid, dout_last, busy, words_sent, state
  );

  modport slave (
    input  in_data, in_valid, bit_en,
    output in_ready, dout, dout_valid, dout_last, busy, words_sent, state
  );
endinterface

// File: rtl/bit_serializer.sv
// Double-buffered parallel-to-serial converter: a holding register refills
// while the shift register drains, so back-to-back words leave with no gap.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic           clk,
  input  logic           rst,
  bit_serializer_if.slave bus
);

  localparam int BL_W = $clog2(WIDTH);
  localparam logic [BL_W-1:0] LAST_IDX = BL_W'(WIDTH - 1);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BL_W-1:0]  bits_left_q, bits_left_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_last_q, dout_last_d;
  logic [CNT_W-1:0] words_q, words_d;
  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shreg_d      = shreg_q;
    bits_left_d  = bits_left_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    words_d      = words_q;
    shifted      = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    // Cannot collide with a load below: loads only happen while hold_full_q=1.
    if (bus.in_valid && !hold_full_q) begin
      hold_d      = bus.in_data;
      hold_full_d = 1'b1;
    end

    if (bus.bit_en) begin
      if (bits_left_q != '0) begin
        shreg_d      = shifted;
        dout_d       = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
        dout_valid_d = 1'b1;
        bits_left_d  = bits_left_q - BL_W'(1);
        dout_last_d  = (bits_left_q == BL_W'(1));
        if (bits_left_q == BL_W'(1)) begin
          words_d = words_q + CNT_W'(1);
        end
      end else if (hold_full_q) begin
        shreg_d      = hold_q;
        dout_d       = MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];
        dout_valid_d = 1'b1;
        dout_last_d  = 1'b0;
        bits_left_d  = LAST_IDX;
        hold_full_d  = 1'b0;
      end else begin
        dout_d       = IDLE_LEVEL;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
      end
    end

    state_d = dout_valid_d ? ST_SHIFT : ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shreg_q      <= '0;
      bits_left_q  <= '0;
      dout_q       <= IDLE_LEVEL;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      words_q      <= '0;
      state_q      <= ST_IDLE;
    end else begin
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shreg_q      <= shreg_d;
      bits_left_q  <= bits_left_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      words_q      <= words_d;
      state_q      <= state_d;
    end
  end

  assign bus.in_ready   = !hold_full_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.words_sent = words_q;
  assign bus.state      = state_q;
  assign bus.busy       = hold_full_q || (bits_left_q != '0) || (dout_valid_q && !dout_last_q);

endmodule

// File: tb/tb_bit_serializer.sv
// Drives an MSB-first/idle-0 and an LSB-first/idle-1 serializer with the same
// word stream and checks both every cycle against a word-level model.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       bit_en   = 1'b0;

  bit_serializer_if #(.WIDTH(8)) if_a ();
  bit_serializer_if #(.WIDTH(8)) if_b ();

  assign if_a.in_data  = in_data;
  assign if_a.in_valid = in_valid;
  assign if_a.bit_en   = bit_en;
  assign if_b.in_data  = in_data;
  assign if_b.in_valid = in_valid;
  assign if_b.bit_en   = bit_en;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  // ---------------- reference model ----------------
  // Word-level view: a word waiting in the holding slot, the word on the wire
  // and how many of its bits have already appeared on dout.
  logic [7:0]  prod_q[$];
  logic [7:0]  m_hold[$];
  logic [7:0]  m_cur   = 8'h00;
  int          m_pos   = 0;
  logic        m_valid = 1'b0;
  logic        m_last  = 1'b0;
  logic [15:0] m_words = 16'h0000;

  int n_cmp = 0;
  int n_bad = 0;
  int run_len = 0;
  int max_run = 0;

  task automatic model_reset();
    m_hold.delete();
    prod_q.delete();
    m_cur   = 8'h00;
    m_pos   = 0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_words = 16'h0000;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic       exp_a, exp_b, exp_ready, exp_busy;
    logic [1:0] exp_st;
    exp_a     = m_valid ? m_cur[8 - m_pos] : 1'b0;
    exp_b     = m_valid ? m_cur[m_pos - 1] : 1'b1;
    exp_ready = (m_hold.size() == 0);
    exp_busy  = (m_hold.size() != 0) || (m_valid && m_pos < 8);
    exp_st    = m_valid ? 2'b10 : 2'b01;
    chk("dout_a",  16'(if_a.dout), 16'(exp_a));
    chk("dout_b",  16'(if_b.dout), 16'(exp_b));
    chk("valid_a", 16'(if_a.dout_valid), 16'(m_valid));
    chk("valid_b", 16'(if_b.dout_valid), 16'(m_valid));
    chk("last_a",  16'(if_a.dout_last), 16'(m_last));
    chk("last_b",  16'(if_b.dout_last), 16'(m_last));
    chk("ready_a", 16'(if_a.in_ready), 16'(exp_ready));
    chk("ready_b", 16'(if_b.in_ready), 16'(exp_ready));
    chk("busy_a",  16'(if_a.busy), 16'(exp_busy));
    chk("busy_b",  16'(if_b.busy), 16'(exp_busy));
    chk("words_a", if_a.words_sent, m_words);
    chk("words_b", if_b.words_sent, m_words);
    chk("state_a", 16'(if_a.state), 16'(exp_st));
  endtask

  // ---------------- driver ----------------
  task automatic drive_producer();
    in_valid = (prod_q.size() != 0);
    in_data  = (prod_q.size() != 0) ? prod_q[0] : 8'h00;
  endtask

  // Called at posedge+1; applies bit_en, advances one edge, checks at posedge+1.
  task automatic step(input logic en);
    logic acc;
    bit_en = en;
    acc = in_valid && (m_hold.size() == 0);
    @(posedge clk);
    if (en) begin
      if (m_valid && m_pos < 8) begin
        m_pos++;
        m_last = (m_pos == 8);
        if (m_last) m_words++;
      end else if (m_hold.size() != 0) begin
        m_cur   = m_hold.pop_front();
        m_pos   = 1;
        m_valid = 1'b1;
        m_last  = 1'b0;
      end else begin
        m_valid = 1'b0;
        m_last  = 1'b0;
      end
    end
    if (acc) begin
      m_hold.push_back(in_data);
      void'(prod_q.pop_front());
    end
    #1;
    drive_producer();
    check_all();
    if (if_a.dout_valid) run_len++; else run_len = 0;
    if (run_len > max_run) max_run = run_len;
  endtask

  task automatic send(input logic [7:0] w);
    prod_q.push_back(w);
    drive_producer();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    check_all();

    // single word, first bit one cycle after acceptance
    send(8'hA5);
    for (int i = 0; i < 14; i++) step(1'b1);
    chk("a5_words", if_a.words_sent, 16'd1);

    // four back-to-back words must leave as one unbroken 32-bit run
    max_run = 0;
    run_len = 0;
    for (int i = 0; i < 4; i++) send(8'h55);
    for (int i = 0; i < 40; i++) step(1'b1);
    chk("gapless_run", 16'(max_run), 16'd32);
    chk("b2b_words", if_a.words_sent, 16'd5);

    // stalled bit strobe with a full holding register
    send(8'hF0);
    send(8'hF0);
    for (int i = 0; i < 60; i++) step(i % 3 == 0);

    // LSB-first / idle-1 word on dut_b
    send(8'h01);
    for (int i = 0; i < 12; i++) step(1'b1);

    // reset in the middle of a word
    send(8'hFF);
    for (int i = 0; i < 20 && !(m_valid && m_pos == 3); i++) step(1'b1);
    chk("mid_reached", 16'(m_pos), 16'd3);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    for (int i = 0; i < 3; i++) step(1'b1);
    send(8'h81);
    for (int i = 0; i < 12; i++) step(1'b1);
    chk("post_rst_words", if_a.words_sent, 16'd1);

    // random words, random gaps and random strobe
    for (int i = 0; i < 600; i++) begin
      if (prod_q.size() < 2 && $urandom_range(0, 3) != 0)
        send(8'($urandom_range(0, 255)));
      step($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 40; i++) step(1'b1);
    chk("drained_words", if_a.words_sent, m_words);
    chk("drained_busy", 16'(if_a.busy), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end that produces the single-bit `din` stream consumed by the overlapping sequence detector (fsm_overlap).
- Accepts WIDTH-bit words over a valid/ready handshake.
- Double-buffers them (one holding register plus one shift register) so that back-to-back words serialize with no gap.
- Emits one bit per `bit_en` cycle, with a per-bit valid and a last-bit marker.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 1'b0: value driven on `dout` whenever no word is being sent.

Ports:
- clk, input, 1: single clock; all state changes on posedge clk.
- rst, input, 1: asynchronous, active-high reset.
- in_data, input, WIDTH: word offered by the producer.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: holding register is empty; a word is accepted on any posedge where in_valid && in_ready.
- bit_en, input, 1: bit-rate strobe; the serializer advances only on edges where bit_en=1.
- dout, output, 1: serial bit, registered (feeds the detector's din).
- dout_valid, output, 1: dout carries a data bit (0 = idle fill).
- dout_last, output, 1: dout is the final bit of a word.
- busy, output, 1: a word is in the shifter or the holding register.
- words_sent, output, 16: count of fully transmitted words; wraps from 0xFFFF to 0.

Behaviour:
- Reset (asynchronous, immediate):
  - dout=IDLE_LEVEL, dout_valid=0, dout_last=0, words_sent=0.
  - hold_full=0, bits_left=0; therefore in_ready=1 and busy=0.
  - A partial word is discarded, and no bit is emitted on the edge that releases reset.
- State:
  - hold_reg[WIDTH] and hold_full.
  - shreg[WIDTH] and bits_left[0..WIDTH-1], where bits_left = data bits still to emit after the current dout.
- Conceptual FSM: IDLE (bits_left==0 and last emitted bit not data, or dout_valid=0) and SHIFT (dout_valid=1).
- in_ready = !hold_full, driven combinationally from the register. A producer that holds in_valid high is therefore accepted whenever the holding register is empty.
- Acceptance edge: hold_reg<=in_data, hold_full<=1.
- On a posedge with bit_en=1, exactly one of the following applies, in priority order:
  1. bits_left>0: shift shreg; dout<=next bit; dout_valid<=1; bits_left<=bits_left-1; dout_last<=(bits_left==1).
  2. bits_left==0 and hold_full: dout<=first bit of hold_reg; shreg<=hold_reg; bits_left<=WIDTH-1; hold_full<=0; dout_valid<=1; dout_last<=0.
  3. Otherwise: dout<=IDLE_LEVEL; dout_valid<=0; dout_last<=0.
- Acceptance and load on the same edge:
  - An acceptance cannot coincide with a load from the holding register, because in_ready is low while hold_full=1.
  - A word accepted at edge N can load no earlier than edge N+1. Minimum latency from acceptance to first bit on dout is 1 cycle, given bit_en=1.
  - When hold_full is cleared at a load edge, in_ready rises the following cycle. That leaves WIDTH-1 bit slots to refill the holding register, so a producer with continuous in_valid sustains gapless output.
- bit_en=0: dout, dout_valid, dout_last, shreg and bits_left all hold. Acceptance into the holding register still occurs.
- words_sent increments on the edge that emits a bit with dout_last=1, i.e. the edge where case 1 executes with bits_left==1.
- Gapless word boundary: the edge after a last bit with bit_en=1 and hold_full=1 takes case 2 directly. dout_valid stays 1 and there is no idle bit.
- busy = hold_full || bits_left>0 || (dout_valid && !dout_last).
- Bit order: MSB_FIRST=1 shifts left and takes shreg[WIDTH-1]; MSB_FIRST=0 shifts right and takes shreg[0].

Decomposition:
- Shared package/include (fsm_defs):
  - IDLE_LEVEL default.
  - words_sent width constant CNT_W=16.
  - Serializer state encodings, one-hot to match the detector's style: ST_IDLE=2'b01, ST_SHIFT=2'b10.
- No sub-module needed. The 16-bit wrap counter may optionally be a tiny event_counter instance, reusable later for counting detector pd pulses.

Test Plan:
- Reset release: hold rst=1 for 2 cycles with in_valid=0 → dout=0, dout_valid=0, in_ready=1, busy=0, words_sent=0.
- Single word: WIDTH=8, MSB_FIRST=1, bit_en=1, send 8'hA5 → dout=1,0,1,0,0,1,0,1 on consecutive cycles; first bit 1 cycle after acceptance; dout_last only on the 8th bit; words_sent=1; then dout_valid=0.
- Back-to-back into the detector: continuous in_valid with 8'h55 repeated 4 times → 32 consecutive dout_valid=1 cycles with no gap, pattern 0101…; downstream fsm_overlap pd count matches its golden model; words_sent=4.
- Stall: bit_en toggling 1,0,0,1… during 8'hF0 → dout holds on bit_en=0 cycles; the 8 data bits still arrive in order; in_ready low while the holding register is full.
- LSB-first and idle level: MSB_FIRST=0, IDLE_LEVEL=1, send 8'h01 → dout=1,0,0,0,0,0,0,0, then constant 1 with dout_valid=0.
- Reset mid-word: assert rst after the 3rd bit of 8'hFF → outputs clear asynchronously; after release, no residual bits; words_sent=0; the next word 8'h81 serializes cleanly.
